// File: rtl/adc_clkgen_pkg.sv
// adc_clkgen_pkg
// Shared definitions for the synchronous SAR clock generator.
//   state_e   : conversion sequencer states
//   idxWidth  : width of the bit index for a given number of bits
//   cntWidth  : width of the shared phase counter so it can hold every
//               programmable length (sample, timeout, settle, digital)
package adc_clkgen_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SAMPLE  = 3'd1,
    ST_COMP    = 3'd2,
    ST_RELEASE = 3'd3,
    ST_DIG     = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  function automatic int idxWidth(input int nBits);
    return (nBits <= 2) ? 1 : $clog2(nBits);
  endfunction

  function automatic int cntWidth(input int sampleW, input int timeoutCyc,
                                  input int settleCyc, input int digCyc);
    int w;
    w = sampleW;
    if ($clog2(timeoutCyc + 1) > w) w = $clog2(timeoutCyc + 1);
    if ($clog2(settleCyc + 1) > w)  w = $clog2(settleCyc + 1);
    if ($clog2(digCyc + 1) > w)     w = $clog2(digCyc + 1);
    return w;
  endfunction

endpackage

// File: rtl/adc_clkgen_sync_if.sv
// adc_clkgen_sync_if
// Control and SAR-side signals of the clock generator.
//   ena_in, start_conv, comp_trig, sample_cycles : controls into the generator
//   clk_comp, clk_dig, sample, busy, conv_done,
//   bit_idx, timeout_err                          : sequencer outputs
// Modports: slave = generator side, master = controller / comparator side.
interface adc_clkgen_sync_if #(
  parameter int NBITS    = 12,
  parameter int SAMPLE_W = 8
);
  import adc_clkgen_pkg::*;

  localparam int IDX_W = idxWidth(NBITS);

  logic                ena_in;
  logic                start_conv;
  logic                comp_trig;
  logic [SAMPLE_W-1:0] sample_cycles;
  logic                clk_comp;
  logic                clk_dig;
  logic                sample;
  logic                busy;
  logic                conv_done;
  logic [IDX_W-1:0]    bit_idx;
  logic                timeout_err;

  modport slave (
    input  ena_in, start_conv, comp_trig, sample_cycles,
    output clk_comp, clk_dig, sample, busy, conv_done, bit_idx, timeout_err
  );

  modport master (
    output ena_in, start_conv, comp_trig, sample_cycles,
    input  clk_comp, clk_dig, sample, busy, conv_done, bit_idx, timeout_err
  );

endinterface

// File: rtl/adc_sync_nff.sv
// adc_sync_nff
// Multi-flop synchroniser for an asynchronous level.
//   clk, rst : system clock, async active-high reset (clears the chain)
//   d_i      : asynchronous input
//   q_o      : input delayed by STAGES clock edges
module adc_sync_nff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift chain; the first flop may go metastable, later ones filter it out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/adc_clkgen_sync.sv
// adc_clkgen_sync
// Cycle-counted SAR conversion sequencer: a sample phase, then NBITS
// comparator / digital clock pairs, then a one-cycle done pulse.
//   clk, rst   : system clock, async active-high reset
//   bus_if     : adc_clkgen_sync_if.slave
//                in : ena_in, start_conv (async), comp_trig (async), sample_cycles
//                out: clk_comp, clk_dig, sample, busy, conv_done, bit_idx, timeout_err
// Build option: define ADC_CLKGEN_WATCHDOG_EN to bound the comparator wait
// to TIMEOUT_CYC cycles and report it on timeout_err (tied low otherwise).
module adc_clkgen_sync
  import adc_clkgen_pkg::*;
#(
  parameter int NBITS       = 12,
  parameter int SAMPLE_W    = 8,
  parameter int SETTLE_CYC  = 2,
  parameter int DIG_CYC     = 2,
  parameter int TIMEOUT_CYC = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  adc_clkgen_sync_if.slave        bus_if
);

  localparam int IDX_W = idxWidth(NBITS);
  localparam int CNT_W = cntWidth(SAMPLE_W, TIMEOUT_CYC, SETTLE_CYC, DIG_CYC);

  logic             startSync;
  logic             compSync;
  logic             startPrev_q;
  logic             startEvent;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] bitIdx_q, bitIdx_d;
  logic             relWait_q, relWait_d;

  logic             sample_q, clkComp_q, clkDig_q, busy_q, convDone_q;

  adc_sync_nff #(.STAGES(SYNC_STAGES)) uStartSync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_if.start_conv),
    .q_o (startSync)
  );

  adc_sync_nff #(.STAGES(SYNC_STAGES)) uCompSync (
    .clk (clk),
    .rst (rst),
    .d_i (bus_if.comp_trig),
    .q_o (compSync)
  );

  // Start edges are tracked every cycle so that edges arriving while busy
  // are consumed rather than queued for the next IDLE.
  assign startEvent = (startSync & ~startPrev_q) | bus_if.ena_in;

`ifdef ADC_CLKGEN_WATCHDOG_EN
  logic timeoutHit;
  logic timeoutErr_q;
`endif

  // Next-state logic. cnt_q is shared by every timed phase and is always
  // cleared on entry to a phase that counts up.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitIdx_d  = bitIdx_q;
    relWait_d = relWait_q;
`ifdef ADC_CLKGEN_WATCHDOG_EN
    timeoutHit = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (startEvent) begin
          state_d = ST_SAMPLE;
          // Counts down to zero, so load length-1; a zero length acts as one.
          cnt_d   = (bus_if.sample_cycles == '0) ? '0
                    : CNT_W'(bus_if.sample_cycles) - CNT_W'(1);
        end
      end
      ST_SAMPLE: begin
        if (cnt_q == '0) begin
          state_d  = ST_COMP;
          bitIdx_d = IDX_W'(NBITS - 1);
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_COMP: begin
        if (compSync) begin
          state_d   = ST_RELEASE;
          relWait_d = 1'b1;
          cnt_d     = '0;
        end
`ifdef ADC_CLKGEN_WATCHDOG_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          // The comparator never answered, so there is no release to wait for.
          state_d    = ST_RELEASE;
          relWait_d  = 1'b0;
          cnt_d      = '0;
          timeoutHit = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      ST_RELEASE: begin
        if (relWait_q) begin
          if (!compSync) relWait_d = 1'b0;
        end else if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          state_d = ST_DIG;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DIG: begin
        if (cnt_q == CNT_W'(DIG_CYC - 1)) begin
          cnt_d = '0;
          if (bitIdx_q == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d  = ST_COMP;
            bitIdx_d = bitIdx_q - IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bitIdx_q    <= IDX_W'(NBITS - 1);
      relWait_q   <= 1'b0;
      startPrev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bitIdx_q    <= bitIdx_d;
      relWait_q   <= relWait_d;
      startPrev_q <= startSync;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up
  // with state_q and are glitch-free towards the analog side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_q   <= 1'b0;
      clkComp_q  <= 1'b0;
      clkDig_q   <= 1'b0;
      busy_q     <= 1'b0;
      convDone_q <= 1'b0;
    end else begin
      sample_q   <= (state_d == ST_SAMPLE);
      clkComp_q  <= (state_d == ST_COMP);
      clkDig_q   <= (state_d == ST_DIG);
      busy_q     <= (state_d == ST_SAMPLE) || (state_d == ST_COMP) ||
                    (state_d == ST_RELEASE) || (state_d == ST_DIG);
      convDone_q <= (state_d == ST_DONE);
    end
  end

`ifdef ADC_CLKGEN_WATCHDOG_EN
  // Sticky until the next conversion begins sampling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timeoutErr_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_SAMPLE)) begin
      timeoutErr_q <= 1'b0;
    end else if (timeoutHit) begin
      timeoutErr_q <= 1'b1;
    end
  end

  assign bus_if.timeout_err = timeoutErr_q;
`else
  assign bus_if.timeout_err = 1'b0;
`endif

  assign bus_if.sample    = sample_q;
  assign bus_if.clk_comp  = clkComp_q;
  assign bus_if.clk_dig   = clkDig_q;
  assign bus_if.busy      = busy_q;
  assign bus_if.conv_done = convDone_q;
  assign bus_if.bit_idx   = bitIdx_q;

endmodule

// File: tb/tb_adc_clkgen_sync.sv
// tb_adc_clkgen_sync
// Directed bench for adc_clkgen_sync with NBITS=4, SETTLE_CYC=2, DIG_CYC=2,
// TIMEOUT_CYC=8, SYNC_STAGES=2. Honours ADC_CLKGEN_WATCHDOG_EN.
module tb_adc_clkgen_sync;

  localparam int NBITS       = 4;
  localparam int DIG_CYC     = 2;
  localparam int TIMEOUT_CYC = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int errors = 0;
  int checks = 0;

  adc_clkgen_sync_if #(.NBITS(NBITS), .SAMPLE_W(8)) bus ();

  adc_clkgen_sync #(
    .NBITS       (NBITS),
    .SAMPLE_W    (8),
    .SETTLE_CYC  (2),
    .DIG_CYC     (DIG_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .SYNC_STAGES (2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus)
  );

  always #5 clk = ~clk;

  // Observation counters, all sampled on the falling edge.
  int doneCnt = 0, digPulseCnt = 0, digWidthBad = 0, overlapCnt = 0, compFallCnt = 0;
  int sampleRun = 0, digRun = 0, compRun = 0, lowRun = 0;
  int lastSampleLen = 0, lastCompLen = 0, lastLowRun = 0;
  int bitLog[$];

  // Pulse-width / count monitor; reset discards any partial pulse.
  always @(negedge clk) begin
    if (rst) begin
      sampleRun = 0;
      digRun    = 0;
      compRun   = 0;
      lowRun    = 0;
    end else begin
      if (bus.sample) sampleRun++;
      else if (sampleRun > 0) begin lastSampleLen = sampleRun; sampleRun = 0; end
      if (bus.clk_dig) begin
        if (digRun == 0) bitLog.push_back(int'(bus.bit_idx));
        digRun++;
      end else if (digRun > 0) begin
        digPulseCnt++;
        if (digRun != DIG_CYC) digWidthBad++;
        digRun = 0;
      end
      if (bus.clk_comp) compRun++;
      else if (compRun > 0) begin lastCompLen = compRun; compFallCnt++; compRun = 0; end
      if (bus.busy) begin
        if (lowRun > 0) lastLowRun = lowRun;
        lowRun = 0;
      end else lowRun++;
      if (bus.conv_done) doneCnt++;
      if (bus.clk_comp && bus.clk_dig) overlapCnt++;
    end
  end

  // Comparator model: decides 2 cycles after clk_comp rises, releases when it falls.
  bit compStuck = 1'b0;
  int compHi = 0;
  initial begin
    bus.comp_trig = 1'b0;
    forever begin
      @(negedge clk);
      if (!compStuck && bus.clk_comp) compHi++;
      else compHi = 0;
      bus.comp_trig = (compHi >= 2);
    end
  end

  task automatic stepCycle();
    @(negedge clk);
    #1;
  endtask

  task automatic pulseStart();
    bus.start_conv = 1'b1;
    repeat (3) stepCycle();
    bus.start_conv = 1'b0;
  endtask

  task automatic waitDone(input int target, input int budget, output bit ok);
    int n;
    n = 0;
    while (doneCnt < target && n < budget) begin
      stepCycle();
      n++;
    end
    ok = (doneCnt >= target);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) stepCycle();
    checks++; if (bus.sample !== 1'b0)      begin errors++; $display("[TB] FAIL reset_sample: got %b want 0", bus.sample); end
    checks++; if (bus.clk_comp !== 1'b0)    begin errors++; $display("[TB] FAIL reset_clk_comp: got %b want 0", bus.clk_comp); end
    checks++; if (bus.clk_dig !== 1'b0)     begin errors++; $display("[TB] FAIL reset_clk_dig: got %b want 0", bus.clk_dig); end
    checks++; if (bus.busy !== 1'b0)        begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.conv_done !== 1'b0)   begin errors++; $display("[TB] FAIL reset_conv_done: got %b want 0", bus.conv_done); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_timeout_err: got %b want 0", bus.timeout_err); end
    checks++; if (bus.bit_idx !== 2'd3)     begin errors++; $display("[TB] FAIL reset_bit_idx: got %0d want 3", bus.bit_idx); end
    rst = 1'b0;
    repeat (5) stepCycle();
    checks++; if (bus.busy !== 1'b0)        begin errors++; $display("[TB] FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_single();
    int d0, p0, w0, o0, sz;
    bit ok;
    d0 = doneCnt; p0 = digPulseCnt; w0 = digWidthBad; o0 = overlapCnt;
    bus.sample_cycles = 8'd3;
    pulseStart();
    waitDone(d0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL single_done: got %0d pulses want %0d", doneCnt - d0, 1); end
    checks++; if (lastSampleLen !== 3) begin errors++; $display("[TB] FAIL single_sample_len: got %0d want 3", lastSampleLen); end
    checks++; if (digPulseCnt - p0 !== 4) begin errors++; $display("[TB] FAIL single_dig_pulses: got %0d want 4", digPulseCnt - p0); end
    checks++; if (digWidthBad - w0 !== 0) begin errors++; $display("[TB] FAIL single_dig_width: got %0d bad want 0", digWidthBad - w0); end
    checks++; if (overlapCnt - o0 !== 0) begin errors++; $display("[TB] FAIL single_overlap: got %0d want 0", overlapCnt - o0); end
    sz = bitLog.size();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sz < 4 || bitLog[sz - 4 + k] !== 3 - k) begin
        errors++;
        $display("[TB] FAIL single_bit_idx%0d: got %0d want %0d", k, (sz < 4) ? -1 : bitLog[sz - 4 + k], 3 - k);
      end
    end
    repeat (2) stepCycle();
    checks++; if (bus.busy !== 1'b0 || bus.conv_done !== 1'b0) begin errors++; $display("[TB] FAIL single_after: busy=%b done=%b want 0 0", bus.busy, bus.conv_done); end
    repeat (20) stepCycle();
    checks++; if (doneCnt !== d0 + 1) begin errors++; $display("[TB] FAIL single_extra_done: got %0d want %0d", doneCnt, d0 + 1); end
  endtask

  task automatic test_sample_zero();
    int d0;
    bit ok;
    d0 = doneCnt;
    bus.sample_cycles = 8'd0;
    pulseStart();
    waitDone(d0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL zero_done: got %0d want 1", doneCnt - d0); end
    checks++; if (lastSampleLen !== 1) begin errors++; $display("[TB] FAIL zero_sample_len: got %0d want 1", lastSampleLen); end
  endtask

  task automatic test_back_to_back();
    int d0, n;
    bit ok;
    d0 = doneCnt;
    bus.sample_cycles = 8'd2;
    bus.ena_in = 1'b1;
    for (int c = 2; c <= 3; c++) begin
      waitDone(d0 + c, 400, ok);
      checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_done%0d: got %0d want %0d", c, doneCnt - d0, c); end
      n = 0;
      while (!bus.busy && n < 10) begin stepCycle(); n++; end
      checks++; if (lastLowRun !== 2) begin errors++; $display("[TB] FAIL b2b_gap%0d: got %0d want 2", c, lastLowRun); end
    end
    bus.ena_in = 1'b0;
    waitDone(d0 + 4, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL b2b_final_done: got %0d want 4", doneCnt - d0); end
    repeat (40) stepCycle();
    checks++; if (doneCnt !== d0 + 4) begin errors++; $display("[TB] FAIL b2b_stop: got %0d want %0d", doneCnt - d0, 4); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("[TB] FAIL b2b_idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_drop_while_busy();
    int d0, n;
    bit ok;
    d0 = doneCnt;
    bus.sample_cycles = 8'd1;
    pulseStart();
    n = 0;
    while (!bus.busy && n < 10) begin stepCycle(); n++; end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL drop_busy: got %b want 1", bus.busy); end
    for (int t = 0; t < 3; t++) begin
      bus.start_conv = 1'b1;
      repeat (3) stepCycle();
      bus.start_conv = 1'b0;
      repeat (3) stepCycle();
    end
    waitDone(d0 + 1, 400, ok);
    repeat (30) stepCycle();
    checks++; if (doneCnt !== d0 + 1) begin errors++; $display("[TB] FAIL drop_count1: got %0d want 1", doneCnt - d0); end
    pulseStart();
    waitDone(d0 + 2, 400, ok);
    repeat (30) stepCycle();
    checks++; if (doneCnt !== d0 + 2) begin errors++; $display("[TB] FAIL drop_count2: got %0d want 2", doneCnt - d0); end
  endtask

  task automatic test_watchdog();
    int d0, f0, n;
    bit ok;
    d0 = doneCnt; f0 = compFallCnt;
    compStuck = 1'b1;
    bus.sample_cycles = 8'd2;
    pulseStart();
`ifdef ADC_CLKGEN_WATCHDOG_EN
    n = 0;
    while (compFallCnt == f0 && n < 100) begin stepCycle(); n++; end
    checks++; if (compFallCnt == f0) begin errors++; $display("[TB] FAIL wd_comp_exit: got stuck want exit"); end
    checks++; if (lastCompLen !== TIMEOUT_CYC) begin errors++; $display("[TB] FAIL wd_comp_len: got %0d want %0d", lastCompLen, TIMEOUT_CYC); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err_set: got %b want 1", bus.timeout_err); end
    waitDone(d0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL wd_done: got %0d want 1", doneCnt - d0); end
    checks++; if (bus.timeout_err !== 1'b1) begin errors++; $display("[TB] FAIL wd_err_sticky: got %b want 1", bus.timeout_err); end
    compStuck = 1'b0;
    bus.start_conv = 1'b1;
    n = 0;
    while (!bus.sample && n < 10) begin stepCycle(); n++; end
    bus.start_conv = 1'b0;
    checks++; if (bus.sample !== 1'b1) begin errors++; $display("[TB] FAIL wd_restart: got %b want 1", bus.sample); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL wd_err_clear: got %b want 0", bus.timeout_err); end
    waitDone(d0 + 2, 400, ok);
    checks++; if (!ok || bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL wd_clean_conv: done=%0d err=%b want 2 0", doneCnt - d0, bus.timeout_err); end
`else
    repeat (100) stepCycle();
    checks++; if (bus.clk_comp !== 1'b1) begin errors++; $display("[TB] FAIL nowd_clk_comp: got %b want 1", bus.clk_comp); end
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("[TB] FAIL nowd_busy: got %b want 1", bus.busy); end
    checks++; if (doneCnt !== d0) begin errors++; $display("[TB] FAIL nowd_done: got %0d want 0", doneCnt - d0); end
    checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("[TB] FAIL nowd_err: got %b want 0", bus.timeout_err); end
    rst = 1'b1;
    stepCycle();
    checks++; if (bus.clk_comp !== 1'b0) begin errors++; $display("[TB] FAIL nowd_reset: got %b want 0", bus.clk_comp); end
    rst = 1'b0;
    compStuck = 1'b0;
    repeat (3) stepCycle();
`endif
  endtask

  task automatic test_reset_mid();
    int d0, p0, w0, n, sz;
    bit ok;
    d0 = doneCnt;
    bus.sample_cycles = 8'd2;
    pulseStart();
    n = 0;
    while (!(bus.clk_dig && bus.bit_idx == 2'd2) && n < 300) begin stepCycle(); n++; end
    checks++; if (!(bus.clk_dig && bus.bit_idx == 2'd2)) begin errors++; $display("[TB] FAIL rmid_reach: dig=%b idx=%0d want 1 2", bus.clk_dig, bus.bit_idx); end
    #2 rst = 1'b1;
    #1;
    checks++; if ({bus.sample, bus.clk_comp, bus.clk_dig, bus.busy, bus.conv_done} !== 5'b0) begin
      errors++; $display("[TB] FAIL rmid_async_outputs: got %b want 00000", {bus.sample, bus.clk_comp, bus.clk_dig, bus.busy, bus.conv_done});
    end
    checks++; if (bus.bit_idx !== 2'd3) begin errors++; $display("[TB] FAIL rmid_bit_idx: got %0d want 3", bus.bit_idx); end
    stepCycle();
    rst = 1'b0;
    repeat (20) stepCycle();
    checks++; if (doneCnt !== d0) begin errors++; $display("[TB] FAIL rmid_no_done: got %0d want 0", doneCnt - d0); end
    p0 = digPulseCnt; w0 = digWidthBad;
    pulseStart();
    waitDone(d0 + 1, 400, ok);
    checks++; if (!ok) begin errors++; $display("[TB] FAIL rmid_clean_done: got %0d want 1", doneCnt - d0); end
    checks++; if (digPulseCnt - p0 !== 4 || digWidthBad !== w0) begin
      errors++; $display("[TB] FAIL rmid_clean_dig: pulses=%0d bad=%0d want 4 0", digPulseCnt - p0, digWidthBad - w0);
    end
    checks++; if (lastSampleLen !== 2) begin errors++; $display("[TB] FAIL rmid_sample_len: got %0d want 2", lastSampleLen); end
    sz = bitLog.size();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (sz < 4 || bitLog[sz - 4 + k] !== 3 - k) begin
        errors++;
        $display("[TB] FAIL rmid_bit_idx%0d: got %0d want %0d", k, (sz < 4) ? -1 : bitLog[sz - 4 + k], 3 - k);
      end
    end
  endtask

  initial begin
    bus.ena_in        = 1'b0;
    bus.start_conv    = 1'b0;
    bus.sample_cycles = 8'd3;
    test_reset();
    test_single();
    test_sample_zero();
    test_back_to_back();
    test_drop_while_busy();
    test_watchdog();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "[TB] time limit");
  end

endmodule

// File: doc/adc_clkgen_sync.md
Name: adc_clkgen_sync

Overview:
- Synchronous, parametrised successor to the delay-line SAR clock generator.
- Sequences one SAR conversion from a single system clock: sample phase, then NBITS comparator/digital clock pairs, then a done pulse.
- Replaces the fixed 5 ns delay chains with cycle counters.
- Sits between the start/enable controls and the SAR comparator + digital SAR register.

Parameters:
NBITS, 12, number of bit-decision cycles per conversion (>=2)
SAMPLE_W, 8, width of runtime sample-length input
SETTLE_CYC, 2, cycles clk_comp stays low after comparator release before clk_dig (>=1)
DIG_CYC, 2, clk_dig high time in cycles (>=1)
TIMEOUT_CYC, 64, comparator wait limit in cycles (watchdog builds only)
SYNC_STAGES, 2, synchroniser depth for start_conv and comp_trig (>=2)

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
ena_in  in  1  continuous mode: back-to-back conversions while high
start_conv  in  1  async start request; rising edge starts one conversion
comp_trig  in  1  async comparator-ready (high = decision made)
sample_cycles  in  SAMPLE_W  sample-phase length; 0 treated as 1
clk_comp  out  1  comparator clock (high = evaluate)
clk_dig  out  1  SAR logic clock pulse, one per bit
sample  out  1  sampling-switch enable
busy  out  1  conversion in progress
conv_done  out  1  one-cycle pulse at end of conversion
bit_idx  out  $clog2(NBITS)  bit being resolved, MSB = NBITS-1
timeout_err  out  1  sticky comparator timeout flag (watchdog builds)

Behaviour:
- Reset: all outputs 0, state IDLE, bit_idx = NBITS-1, synchronisers cleared.
  - Async assert; deassert takes effect on the next clk edge.
  - Reset mid-conversion aborts immediately; no conv_done is emitted.
- start_conv and comp_trig each pass through SYNC_STAGES flops.
  - Start event = synced start_conv 0->1, or ena_in==1, evaluated in IDLE only.
  - Start edges while busy are dropped, not queued.
- All outputs are registered, decoded from state.
- States:
  - IDLE: busy=0. Start event -> SAMPLE; latch sample_cycles (0 -> 1).
  - SAMPLE: sample=1, busy=1, for exactly the latched count. Then -> COMP with bit_idx=NBITS-1.
  - COMP: clk_comp=1 until synced comp_trig==1, then -> RELEASE.
  - RELEASE: clk_comp=0. Wait for synced comp_trig==0, then count SETTLE_CYC, then -> DIG.
  - DIG: clk_dig=1 for DIG_CYC cycles.
    - If bit_idx==0 -> DONE.
    - Else bit_idx decrements and -> COMP.
  - DONE: conv_done=1 for one cycle, busy=0.
    - Next state IDLE; if ena_in==1 the IDLE start fires on the following cycle.
- Invariant: clk_comp and clk_dig never high in the same cycle.
- ena_in falling mid-conversion: current conversion completes normally.
- comp_trig already high on COMP entry: the check uses the synced value, so COMP lasts minimum 1 cycle.
- Minimum conversion length = 1 + NBITS*(2 + SETTLE_CYC + DIG_CYC) + 1 cycles plus sync latency.

Optional Feature:
ADC_CLKGEN_WATCHDOG_EN:
- Defined: a counter runs in COMP. After TIMEOUT_CYC cycles without synced comp_trig, force -> RELEASE.
  - In RELEASE, skip the wait-for-release and go straight to the settle count.
  - Set timeout_err; it is cleared only at the next SAMPLE entry.
- Undefined: COMP waits indefinitely; timeout_err tied to 0; no counter logic.

Decomposition:
- Package adc_clkgen_pkg: state enum (IDLE, SAMPLE, COMP, RELEASE, DIG, DONE) and a localparam function for bit_idx width.
- Sub-module adc_sync_nff: SYNC_STAGES-deep synchroniser with async active-high reset. Instantiated twice.

Test Plan:
- Single conversion, NBITS=4, sample_cycles=3, comparator model responds 2 cycles after clk_comp rise:
  - sample high exactly 3 cycles;
  - 4 clk_dig pulses, each DIG_CYC wide;
  - bit_idx 3,2,1,0;
  - one conv_done; busy low after.
- sample_cycles=0 -> sample high exactly 1 cycle.
- ena_in held high for 3 conversions -> 3 conv_done pulses, no extra idle gap beyond 1 cycle; ena_in dropped mid-conv -> that conversion finishes, then IDLE.
- start_conv toggled during busy -> ignored; conv_done count equals number of idle-time edges.
- Comparator stuck low, watchdog build, TIMEOUT_CYC=8:
  - COMP exits after 8 cycles and timeout_err=1;
  - next start clears it.
  - Non-watchdog build: clk_comp stays high indefinitely.
- rst pulsed during DIG of bit 2 -> outputs 0 asynchronously, no conv_done; next start runs a full clean conversion.
